subservient_dbg_loader: RTL and testbench

Wishbone initiator that drives the debug Wishbone port of the subservient SoC to load a program image into its SRAM before the core runs. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes each word to an incrementing address. When the load completes it releases debug mode so the core starts executing. It sits between the chip-level byte source (GPIO/LA shim) and the SoC debug port.

---
 rtl/subservient_dbg_loader.sv | 196 +++++++++++++++++++
 tb/tb_subservient_dbg_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/subservient_dbg_loader.sv
// Debug-port program loader: packs a byte stream into little-endian words and writes them to SRAM over Wishbone.
// Define SUBSERVIENT_LOADER_VERIFY_EN to read back and compare each word after writing it.
module subservient_dbg_loader #(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int          AW       = 8,
    parameter int          TIMEOUT  = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_len,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte,
    output logic          o_byte_ready,
    output logic [31:0]   o_wb_dbg_adr,
    output logic [31:0]   o_wb_dbg_dat,
    output logic [3:0]    o_wb_dbg_sel,
    output logic          o_wb_dbg_we,
    output logic          o_wb_dbg_stb,
    input  logic [31:0]   i_wb_dbg_rdt,
    input  logic          i_wb_dbg_ack,
    output logic          o_debug_mode,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] len_q, len_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [31:0]   word_q, word_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;

    logic          ready_q, ready_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic          dbg_q, dbg_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          ack;
    logic          last;
    logic          tmo;

    // Acks are only meaningful while a cycle is actually on the bus.
    assign ack  = i_wb_dbg_ack & stb_q;
    assign last = ({1'b0, idx_q} + (AW+1)'(1)) == {1'b0, len_q};
    assign tmo  = tcnt_q == TW'(TIMEOUT - 1);

`ifndef SUBSERVIENT_LOADER_VERIFY_EN
    logic unused_rdt;
    assign unused_rdt = ^i_wb_dbg_rdt;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= BASE_ADR;
            dbg_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dbg_q   <= dbg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    err_d   = 1'b0;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    len_d   = i_len;
                    state_d = (i_len == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (i_byte_valid && ready_q) begin
                    word_d[{bcnt_q, 3'b000} +: 8] = i_byte;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (ack) begin
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_COLLECT;
                    end
`endif
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (ack) begin
                    if (i_wb_dbg_rdt != word_q) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_COLLECT;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // Restarts from zero whenever a bus state is (re)entered.
        tcnt_d = (state_d == state_q && stb_q) ? tcnt_q + TW'(1) : '0;
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        ready_d = state_d == S_COLLECT;
        we_d    = state_d == S_WRITE;
        stb_d   = state_d == S_WRITE;
        busy_d  = state_d == S_COLLECT || state_d == S_WRITE;
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
        stb_d   = stb_d  || state_d == S_VERIFY;
        busy_d  = busy_d || state_d == S_VERIFY;
`endif
        done_d  = state_d == S_DONE;
        dbg_d   = !(state_d == S_DONE && !err_d);
        adr_d   = BASE_ADR + (32'(idx_d) << 2);
    end

    assign o_byte_ready = ready_q;
    assign o_wb_dbg_adr = adr_q;
    assign o_wb_dbg_dat = word_q;
    assign o_wb_dbg_sel = 4'hF;
    assign o_wb_dbg_we  = we_q;
    assign o_wb_dbg_stb = stb_q;
    assign o_debug_mode = dbg_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_subservient_dbg_loader.sv
// Directed bench for subservient_dbg_loader with a small Wishbone SRAM responder.
module tb_subservient_dbg_loader;

    localparam int TIMEOUT = 8;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_len = '0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = '0;
    logic        o_byte_ready;
    logic [31:0] o_wb_dbg_adr;
    logic [31:0] o_wb_dbg_dat;
    logic [3:0]  o_wb_dbg_sel;
    logic        o_wb_dbg_we;
    logic        o_wb_dbg_stb;
    logic [31:0] i_wb_dbg_rdt = '0;
    logic        i_wb_dbg_ack = 1'b0;
    logic        o_debug_mode;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    subservient_dbg_loader #(
        .BASE_ADR(32'h0000_0000),
        .AW      (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_byte_valid(i_byte_valid),
        .i_byte      (i_byte),
        .o_byte_ready(o_byte_ready),
        .o_wb_dbg_adr(o_wb_dbg_adr),
        .o_wb_dbg_dat(o_wb_dbg_dat),
        .o_wb_dbg_sel(o_wb_dbg_sel),
        .o_wb_dbg_we (o_wb_dbg_we),
        .o_wb_dbg_stb(o_wb_dbg_stb),
        .i_wb_dbg_rdt(i_wb_dbg_rdt),
        .i_wb_dbg_ack(i_wb_dbg_ack),
        .o_debug_mode(o_debug_mode),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Responder: acks after ack_lat stb cycles, stores writes, serves reads.
    logic        ack_en  = 1'b1;
    int          ack_lat = 1;
    logic        corrupt = 1'b0;
    int          lat_cnt = 0;
    int          nwr = 0;
    int          nrd = 0;
    int          stb_cyc = 0;
    logic [31:0] mem [0:255];
    logic [31:0] wr_adr [0:15];
    logic [31:0] wr_dat [0:15];

    always @(negedge i_clk) begin
        if (o_wb_dbg_stb) stb_cyc++;
        if (o_wb_dbg_stb && !i_wb_dbg_ack && ack_en) begin
            if (lat_cnt >= ack_lat) begin
                i_wb_dbg_ack = 1'b1;
                lat_cnt = 0;
                if (o_wb_dbg_we) begin
                    mem[o_wb_dbg_adr[9:2]] = o_wb_dbg_dat;
                    wr_adr[nwr[3:0]] = o_wb_dbg_adr;
                    wr_dat[nwr[3:0]] = o_wb_dbg_dat;
                    nwr++;
                end else begin
                    nrd++;
                    i_wb_dbg_rdt = (corrupt && o_wb_dbg_adr == 32'h0) ? 32'hDEADBEEF
                                                                      : mem[o_wb_dbg_adr[9:2]];
                end
            end else begin
                lat_cnt++;
            end
        end else begin
            i_wb_dbg_ack = 1'b0;
            lat_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [7:0] len);
        i_start = 1'b1;
        i_len   = len;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        i_byte = b;
        i_byte_valid = 1'b1;
        while (!o_byte_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) chk("byte_ready_seen", {31'b0, o_byte_ready}, 32'h1);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!o_done && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk("done_seen", {31'b0, o_done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    int wr0;
    int rd0;
    int sc0;

    initial begin
        // Reset state
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_debug_mode", {31'b0, o_debug_mode}, 32'h1);
        chk("rst_stb",        {31'b0, o_wb_dbg_stb}, 32'h0);
        chk("rst_we",         {31'b0, o_wb_dbg_we},  32'h0);
        chk("rst_ready",      {31'b0, o_byte_ready}, 32'h0);
        chk("rst_done",       {31'b0, o_done},       32'h0);
        chk("rst_busy",       {31'b0, o_busy},       32'h0);
        chk("rst_err",        {31'b0, o_err},        32'h0);
        chk("rst_adr",        o_wb_dbg_adr,          32'h0);
        chk("rst_dat",        o_wb_dbg_dat,          32'h0);
        chk("rst_sel",        {28'b0, o_wb_dbg_sel}, 32'hF);

        // Zero-length load: DONE the very next cycle, no bus traffic
        sc0 = stb_cyc;
        start_load(8'd0);
        chk("len0_done",  {31'b0, o_done},       32'h1);
        chk("len0_busy",  {31'b0, o_busy},       32'h0);
        chk("len0_debug", {31'b0, o_debug_mode}, 32'h0);
        repeat (4) @(negedge i_clk);
        chk("len0_no_stb", stb_cyc - sc0, 32'h0);

        // Two-word load, ack one cycle after stb
        wr0 = nwr;
        start_load(8'd2);
        chk("ld_busy",  {31'b0, o_busy},       32'h1);
        chk("ld_ready", {31'b0, o_byte_ready}, 32'h1);
        chk("ld_done_clr", {31'b0, o_done},    32'h0);
        chk("ld_debug", {31'b0, o_debug_mode}, 32'h1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        chk("w0_stb",   {31'b0, o_wb_dbg_stb}, 32'h1);
        chk("w0_we",    {31'b0, o_wb_dbg_we},  32'h1);
        chk("w0_ready", {31'b0, o_byte_ready}, 32'h0);
        chk("w0_adr",   o_wb_dbg_adr,          32'h0);
        chk("w0_dat",   o_wb_dbg_dat,          32'h04030201);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        wait_done();
        chk("ld_nwr",     nwr - wr0,        32'd2);
        chk("ld_adr0",    wr_adr[wr0[3:0]], 32'h0);
        chk("ld_dat0",    wr_dat[wr0[3:0]], 32'h04030201);
        chk("ld_adr1",    wr_adr[4'(wr0 + 1)], 32'h4);
        chk("ld_dat1",    wr_dat[4'(wr0 + 1)], 32'h08070605);
        chk("ld_debug_0", {31'b0, o_debug_mode}, 32'h0);
        chk("ld_err",     {31'b0, o_err},        32'h0);
        chk("ld_busy_0",  {31'b0, o_busy},       32'h0);
        chk("ld_stb_0",   {31'b0, o_wb_dbg_stb}, 32'h0);

        // Ack withheld: timeout after TIMEOUT strobe cycles
        ack_en = 1'b0;
        start_load(8'd1);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        sc0 = stb_cyc;
        send_byte(8'hA4);
        wait_done();
        chk("tmo_stb_cycles", stb_cyc - sc0, TIMEOUT);
        chk("tmo_err",   {31'b0, o_err},        32'h1);
        chk("tmo_debug", {31'b0, o_debug_mode}, 32'h1);
        chk("tmo_stb",   {31'b0, o_wb_dbg_stb}, 32'h0);
        ack_en = 1'b1;

        // Reset while word 1 is on the bus
        ack_lat = 3;
        start_load(8'd2);
        chk("rr_err_clr", {31'b0, o_err}, 32'h0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        chk("rr_stb_w1", {31'b0, o_wb_dbg_stb}, 32'h1);
        chk("rr_adr_w1", o_wb_dbg_adr,          32'h4);
        #2 i_rst = 1'b1;
        #1;
        chk("rr_stb_async", {31'b0, o_wb_dbg_stb}, 32'h0);
        chk("rr_busy",      {31'b0, o_busy},       32'h0);
        chk("rr_ready",     {31'b0, o_byte_ready}, 32'h0);
        chk("rr_debug",     {31'b0, o_debug_mode}, 32'h1);
        @(negedge i_clk);
        i_rst = 1'b0;
        ack_lat = 1;
        wr0 = nwr;
        start_load(8'd1);
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        chk("rr_restart_adr", o_wb_dbg_adr, 32'h0);
        wait_done();
        chk("rr_nwr", nwr - wr0,        32'd1);
        chk("rr_dat", wr_dat[wr0[3:0]], 32'hC4C3C2C1);

`ifdef SUBSERVIENT_LOADER_VERIFY_EN
        // Read-back mismatch on word 0 stops the load
        corrupt = 1'b1;
        wr0 = nwr;
        rd0 = nrd;
        start_load(8'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        wait_done();
        repeat (10) @(negedge i_clk);
        chk("vf_err",   {31'b0, o_err},        32'h1);
        chk("vf_done",  {31'b0, o_done},       32'h1);
        chk("vf_debug", {31'b0, o_debug_mode}, 32'h1);
        chk("vf_nwr",   nwr - wr0,             32'd1);
        chk("vf_nrd",   nrd - rd0,             32'd1);
        chk("vf_ready", {31'b0, o_byte_ready}, 32'h0);
        corrupt = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
